// File: rtl/sweep_pkg.sv
// Shared types and constants for the PLL frequency sweep sequencer.
package sweep_pkg;

  localparam int STEP_W       = 9;
  localparam int TMR_W        = 32;
  localparam int BLANK_CYCLES = 2;

  localparam int unsigned DWELL_CYCLES_DEF = 32'd50_000_000;
  localparam int unsigned LOCK_TIMEOUT_DEF = 32'd5_000_000;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_REQ       = 3'd1,
    S_BLANK     = 3'd2,
    S_WAIT_LOCK = 3'd3,
    S_DWELL     = 3'd4,
    S_DONE      = 3'd5,
    S_FAULT     = 3'd6
  } state_e;

endpackage

// File: rtl/sweep_timer.sv
// Loadable down-counter with zero flag; load wins over decrement, holds at zero.
module sweep_timer #(
  parameter int W = 32
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         load_i,
  input  logic         dec_i,
  input  logic [W-1:0] load_val_i,
  output logic         zero_o
);

  logic [W-1:0] count_q;

  always_ff @(posedge clk_i) begin
    if (rst_i)                     count_q <= '0;
    else if (load_i)               count_q <= load_val_i;
    else if (dec_i && count_q != '0) count_q <= count_q - 1'b1;
  end

  assign zero_o = (count_q == '0);

endmodule

// File: rtl/sweep_sequencer.sv
// Timed PLL step-request sequencer: REQ -> BLANK -> WAIT_LOCK -> DWELL per step.
// Optional lock watchdog enabled by defining SWEEP_LOCK_TIMEOUT_EN.
module sweep_sequencer
  import sweep_pkg::*;
#(
  parameter int unsigned DWELL_CYCLES = DWELL_CYCLES_DEF,
  parameter int unsigned LOCK_TIMEOUT = LOCK_TIMEOUT_DEF
) (
  input  logic              CLK_50,
  input  logic              reset,
  input  logic              start,
  input  logic              stop,
  input  logic [STEP_W-1:0] num_steps,
  input  logic              freq_ready,
  output logic              next_frequency,
  output logic              sweep_active,
  output logic              sweep_done,
  output logic              dwell_tick,
  output logic [STEP_W-1:0] step_count,
  output logic [2:0]        state_out,
  output logic              lock_fault
);

  state_e              state_q, state_d;
  logic                nf_q;
  logic [STEP_W-1:0]   steps_left_q, steps_left_d;
  logic [STEP_W-1:0]   step_count_q, step_count_d;

  // One timer serves blanking, watchdog and dwell; the phases never overlap.
  logic                tmr_load, tmr_dec, tmr_zero;
  logic [TMR_W-1:0]    tmr_val;

  sweep_timer #(.W(TMR_W)) u_timer (
    .clk_i      (CLK_50),
    .rst_i      (reset),
    .load_i     (tmr_load),
    .dec_i      (tmr_dec),
    .load_val_i (tmr_val),
    .zero_o     (tmr_zero)
  );

  always_ff @(posedge CLK_50) begin
    if (reset) begin
      state_q      <= S_IDLE;
      nf_q         <= 1'b0;
      steps_left_q <= '0;
      step_count_q <= '0;
    end else begin
      state_q      <= state_d;
      nf_q         <= (state_d == S_REQ);
      steps_left_q <= steps_left_d;
      step_count_q <= step_count_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    tmr_load = 1'b0;
    tmr_dec  = 1'b0;
    tmr_val  = '0;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) state_d = (num_steps == '0) ? S_DONE : S_REQ;
      end
      S_REQ: begin
        state_d  = S_BLANK;
        tmr_load = 1'b1;
        tmr_val  = TMR_W'(BLANK_CYCLES - 1);
      end
      S_BLANK: begin
        if (tmr_zero) begin
          state_d  = S_WAIT_LOCK;
          tmr_load = 1'b1;
          tmr_val  = TMR_W'(LOCK_TIMEOUT - 1);
        end else begin
          tmr_dec  = 1'b1;
        end
      end
      S_WAIT_LOCK: begin
        if (freq_ready) begin
          state_d  = S_DWELL;
          tmr_load = 1'b1;
          tmr_val  = TMR_W'(DWELL_CYCLES - 1);
        end
`ifdef SWEEP_LOCK_TIMEOUT_EN
        else if (tmr_zero) state_d = S_FAULT;
        else               tmr_dec = 1'b1;
`endif
      end
      S_DWELL: begin
        if (tmr_zero) state_d = (steps_left_q != '0) ? S_REQ : S_DONE;
        else          tmr_dec = 1'b1;
      end
      S_FAULT: state_d = S_FAULT;
      default: state_d = S_IDLE;
    endcase
    if (stop) state_d = S_IDLE;
  end

  always_comb begin
    steps_left_d = steps_left_q;
    step_count_d = step_count_q;
    if ((state_q == S_IDLE || state_q == S_DONE) && start && !stop) begin
      steps_left_d = num_steps;
      step_count_d = '0;
    end else if (state_q == S_REQ) begin
      // The pulse is already on the wire in REQ, so it counts even if stop arrives.
      steps_left_d = steps_left_q - 1'b1;
      if (step_count_q != '1) step_count_d = step_count_q + 1'b1;
    end
  end

  always_comb begin
    next_frequency = nf_q;
    sweep_active   = !(state_q == S_IDLE || state_q == S_DONE || state_q == S_FAULT);
    sweep_done     = (state_q == S_DONE);
    dwell_tick     = (state_q == S_DWELL) && tmr_zero;
    step_count     = step_count_q;
    state_out      = state_q;
`ifdef SWEEP_LOCK_TIMEOUT_EN
    lock_fault     = (state_q == S_FAULT);
`else
    lock_fault     = 1'b0;
`endif
  end

endmodule

// File: tb/tb_sweep_sequencer.sv
// Directed bench for sweep_sequencer (DWELL_CYCLES=10, LOCK_TIMEOUT=20).
module tb_sweep_sequencer;

  logic       CLK_50 = 1'b0;
  logic       reset, start, stop, freq_ready;
  logic [8:0] num_steps;
  logic       next_frequency, sweep_active, sweep_done, dwell_tick, lock_fault;
  logic [8:0] step_count;
  logic [2:0] state_out;

  int passed = 0;
  int total  = 0;

  always #10 CLK_50 = ~CLK_50;

  sweep_sequencer #(.DWELL_CYCLES(10), .LOCK_TIMEOUT(20)) dut (
    .CLK_50         (CLK_50),
    .reset          (reset),
    .start          (start),
    .stop           (stop),
    .num_steps      (num_steps),
    .freq_ready     (freq_ready),
    .next_frequency (next_frequency),
    .sweep_active   (sweep_active),
    .sweep_done     (sweep_done),
    .dwell_tick     (dwell_tick),
    .step_count     (step_count),
    .state_out      (state_out),
    .lock_fault     (lock_fault)
  );

  typedef struct {
    logic       rst, st, sp;
    logic [8:0] ns;
    logic       rdy;
    logic [2:0] e_state;
    logic       e_nf;
    logic [8:0] e_cnt;
    logic       e_tick, e_done, e_act;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic rst, logic st, logic sp, logic [8:0] ns, logic rdy,
                              logic [2:0] es, logic enf, logic [8:0] ec,
                              logic et, logic ed, logic ea);
    vec_t v;
    v.rst = rst; v.st = st; v.sp = sp; v.ns = ns; v.rdy = rdy;
    v.e_state = es; v.e_nf = enf; v.e_cnt = ec; v.e_tick = et; v.e_done = ed; v.e_act = ea;
    return v;
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endtask

  task automatic tick;
    @(posedge CLK_50);
    #1;
  endtask

  int pulses, ticks, adj_err, since;
  logic prev_nf, prev_tick;

  initial begin
    reset = 1'b1; start = 1'b0; stop = 1'b0; num_steps = '0; freq_ready = 1'b0;

    // Reset, start+stop, zero steps, then a one-step sweep with ready stuck high.
    tbl.push_back(mk(1,0,0,0,0, 0,0,0,0,0,0));
    tbl.push_back(mk(0,1,1,3,0, 0,0,0,0,0,0));
    tbl.push_back(mk(0,1,0,0,0, 5,0,0,0,1,0));
    tbl.push_back(mk(0,0,0,0,0, 5,0,0,0,1,0));
    tbl.push_back(mk(0,1,0,1,1, 1,1,0,0,0,1));
    tbl.push_back(mk(0,0,0,1,1, 2,0,1,0,0,1));
    tbl.push_back(mk(0,0,0,1,1, 2,0,1,0,0,1));
    tbl.push_back(mk(0,0,0,1,1, 3,0,1,0,0,1));
    for (int i = 0; i < 10; i++)
      tbl.push_back(mk(0,0,0,1,1, 4,0,1,(i == 9),0,1));
    tbl.push_back(mk(0,0,0,1,0, 5,0,1,0,1,0));

    for (int r = 0; r < tbl.size(); r++) begin
      reset = tbl[r].rst; start = tbl[r].st; stop = tbl[r].sp;
      num_steps = tbl[r].ns; freq_ready = tbl[r].rdy;
      tick;
      chk($sformatf("row%0d state", r), state_out,      tbl[r].e_state);
      chk($sformatf("row%0d nf", r),    next_frequency, tbl[r].e_nf);
      chk($sformatf("row%0d count", r), step_count,     tbl[r].e_cnt);
      chk($sformatf("row%0d tick", r),  dwell_tick,     tbl[r].e_tick);
      chk($sformatf("row%0d done", r),  sweep_done,     tbl[r].e_done);
      chk($sformatf("row%0d active", r), sweep_active,  tbl[r].e_act);
      chk($sformatf("row%0d fault", r), lock_fault,     0);
    end

    // Basic sweep: 3 steps, ready returns 5 cycles after each pulse.
    start = 1'b1; num_steps = 9'd3; freq_ready = 1'b0; since = 0;
    pulses = 0; ticks = 0; adj_err = 0; prev_nf = 1'b0; prev_tick = 1'b0;
    tick;
    start = 1'b0;
    for (int c = 0; c < 300 && !sweep_done; c++) begin
      if (next_frequency) begin
        pulses++;
        if (prev_nf) adj_err++;
        since = 0;
      end else since++;
      if (prev_tick && !(next_frequency || sweep_done)) adj_err++;
      if (dwell_tick) ticks++;
      prev_nf = next_frequency; prev_tick = dwell_tick;
      freq_ready = (since >= 5);
      tick;
    end
    chk("basic done",    sweep_done, 1);
    chk("basic pulses",  pulses, 3);
    chk("basic ticks",   ticks, 3);
    chk("basic count",   step_count, 3);
    chk("basic adjacent", adj_err, 0);

    // Abort in the second dwell.
    reset = 1'b1; tick; reset = 1'b0;
    start = 1'b1; num_steps = 9'd3; freq_ready = 1'b1;
    tick;
    start = 1'b0;
    pulses = 0;
    for (int i = 0; i < 20; i++) begin
      tick;
      if (next_frequency) pulses++;
    end
    chk("abort pre pulses", pulses, 1);
    chk("abort pre state",  state_out, 4);
    chk("abort pre count",  step_count, 2);
    stop = 1'b1;
    tick;
    stop = 1'b0;
    chk("abort state",  state_out, 0);
    chk("abort count",  step_count, 2);
    chk("abort active", sweep_active, 0);
    pulses = 0;
    for (int i = 0; i < 30; i++) begin
      tick;
      if (next_frequency) pulses++;
    end
    chk("abort no pulses", pulses, 0);
    chk("abort still idle", state_out, 0);

    // Reset while waiting for lock, then restart.
    freq_ready = 1'b0; start = 1'b1; num_steps = 9'd2;
    tick;
    start = 1'b0;
    repeat (3) tick;
    chk("rst pre state", state_out, 3);
    reset = 1'b1;
    tick;
    reset = 1'b0;
    chk("rst state",  state_out, 0);
    chk("rst nf",     next_frequency, 0);
    chk("rst count",  step_count, 0);
    chk("rst active", sweep_active, 0);
    chk("rst done",   sweep_done, 0);
    chk("rst tick",   dwell_tick, 0);
    start = 1'b1;
    tick;
    start = 1'b0;
    chk("restart nf", next_frequency, 1);
    tick;
    chk("restart count", step_count, 1);
    tick; tick;
    chk("restart wait", state_out, 3);

`ifdef SWEEP_LOCK_TIMEOUT_EN
    repeat (19) tick;
    chk("wd still waiting", state_out, 3);
    tick;
    chk("wd fault state", state_out, 6);
    chk("wd lock_fault",  lock_fault, 1);
    chk("wd active",      sweep_active, 0);
    start = 1'b1;
    tick;
    start = 1'b0;
    chk("wd start ignored", state_out, 6);
    stop = 1'b1;
    tick;
    stop = 1'b0;
    chk("wd stop idle",  state_out, 0);
    chk("wd fault clear", lock_fault, 0);
`else
    repeat (50) tick;
    chk("nowd still waiting", state_out, 3);
    chk("nowd no fault", lock_fault, 0);
    stop = 1'b1;
    tick;
    stop = 1'b0;
    chk("nowd stop idle", state_out, 0);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
